plat_type_sched: RTL and testbench

- Decides which platform slot respawns next and which type it gets (Green/Brown/Blue/Yellow).
- Sits between the per-slot scroll logic, which raises `respawn_req` when a platform leaves the bottom of the screen, and the per-slot platform-type registers, which load `type_trigger` when strobed by `grant`.
- Arbitrates slots round-robin and issues at most one respawn per frame tick.
- Raises difficulty (the share of non-Green platforms) as the respawn count grows.

---
 rtl/plat_type_sched.sv | 172 +++++++++++++++++
 tb/tb_plat_type_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plat_type_sched.sv
// Respawn scheduler: picks the next platform slot round-robin, at most once per frame,
// and assigns it a platform type whose mix shifts away from Green as more platforms respawn.
module plat_type_sched #(
    parameter int          NUM_PLAT   = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          LEVEL_STEP = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_tick,
    input  logic [NUM_PLAT-1:0] respawn_req,
    output logic [NUM_PLAT-1:0] grant,
    output logic                type_valid,
    output logic [2:0]          type_trigger,
    output logic [1:0]          level,
    output logic [1:0]          state_dbg
);

    localparam int IW = $clog2(NUM_PLAT);

    localparam logic [2:0] T_GREEN  = 3'b000;
    localparam logic [2:0] T_BROWN  = 3'b001;
    localparam logic [2:0] T_BLUE   = 3'b010;
    localparam logic [2:0] T_YELLOW = 3'b011;

    // Handshake: respawn_req is a level held by the slot; grant is a one-cycle strobe
    // and type_trigger carries the new type in that same cycle (type_valid=1).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PICK  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [2:0]    prev_type_q, prev_type_d;
    logic [2:0]    pick_type_q, pick_type_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [1:0]    level_q, level_d;

    logic [IW-1:0] search_idx;
    logic          search_hit;
    logic [2:0]    raw_type;
    logic [2:0]    mapped_type;

    function automatic logic [IW-1:0] next_slot(input logic [IW-1:0] base, input int step);
        int s;
        s = (int'(base) + step) % NUM_PLAT;
        return IW'(s);
    endfunction

    function automatic logic [2:0] map_type(input logic [1:0] lvl, input logic [3:0] r);
        logic [2:0] t;
        t = T_GREEN;
        case (lvl)
            2'd0: t = T_GREEN;
            2'd1: t = (r >= 4'd12) ? T_BROWN : T_GREEN;
            2'd2: begin
                if (r < 4'd8)       t = T_GREEN;
                else if (r < 4'd12) t = T_BROWN;
                else if (r < 4'd14) t = T_BLUE;
                else                t = T_YELLOW;
            end
            default: begin
                if (r < 4'd4)       t = T_GREEN;
                else if (r < 4'd9)  t = T_BROWN;
                else if (r < 4'd13) t = T_BLUE;
                else                t = T_YELLOW;
            end
        endcase
        return t;
    endfunction

    // Circular search starting just past the last granted slot.
    always_comb begin
        search_idx = ptr_q;
        search_hit = 1'b0;
        for (int i = 1; i <= NUM_PLAT; i++) begin
            if (!search_hit && respawn_req[next_slot(ptr_q, i)]) begin
                search_hit = 1'b1;
                search_idx = next_slot(ptr_q, i);
            end
        end
    end

    // Two Browns in a row can leave the player without a landable platform.
    always_comb begin
        raw_type    = map_type(level_q, lfsr_q[3:0]);
        mapped_type = (raw_type == T_BROWN && prev_type_q == T_BROWN) ? T_GREEN : raw_type;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        prev_type_d = prev_type_q;
        pick_type_d = pick_type_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        case (state_q)
            IDLE: begin
                if (frame_tick && (|respawn_req)) state_d = PICK;
            end
            PICK: begin
                if (search_hit) begin
                    sel_d       = search_idx;
                    pick_type_d = mapped_type;
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                ptr_d       = sel_q;
                prev_type_d = pick_type_q;
                state_d     = IDLE;
                if (cnt_q == 8'(LEVEL_STEP - 1)) begin
                    cnt_d = 8'd0;
                    if (level_q != 2'd3) level_d = level_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            ptr_q       <= IW'(NUM_PLAT - 1);
            sel_q       <= '0;
            prev_type_q <= T_GREEN;
            pick_type_q <= T_GREEN;
            cnt_q       <= 8'd0;
            level_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            prev_type_q <= prev_type_d;
            pick_type_q <= pick_type_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
        end
    end

    // Outputs are masked while Reset is high so an ISSUE cut short by reset emits nothing.
    always_comb begin
        grant        = '0;
        type_valid   = 1'b0;
        type_trigger = prev_type_q;
        level        = level_q;
        if (Reset) begin
            type_trigger = T_GREEN;
            level        = 2'd0;
        end else if (state_q == ISSUE) begin
            grant[sel_q] = 1'b1;
            type_valid   = 1'b1;
            type_trigger = pick_type_q;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_plat_type_sched.sv
// Bench for plat_type_sched: randomized requests/ticks checked cycle by cycle against a
// timestamp-based reference model, plus direct checks of the documented scenarios.
module tb_plat_type_sched;

    localparam int          N    = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          STEP = 16;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         frame_tick = 1'b0;
    logic [N-1:0] respawn_req = '0;
    logic [N-1:0] grant;
    logic         type_valid;
    logic [2:0]   type_trigger;
    logic [1:0]   level;
    logic [1:0]   state_dbg;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    plat_type_sched #(
        .NUM_PLAT   (N),
        .LFSR_SEED  (SEED),
        .LEVEL_STEP (STEP)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .respawn_req  (respawn_req),
        .grant        (grant),
        .type_valid   (type_valid),
        .type_trigger (type_trigger),
        .level        (level),
        .state_dbg    (state_dbg)
    );

    // Reference model: type share per level as upper bounds of r for Green/Brown/Blue.
    int bounds [4][3] = '{'{16, 16, 16}, '{12, 16, 16}, '{8, 12, 14}, '{4, 9, 13}};

    function automatic logic [2:0] ref_type(input int lvl, input int r);
        for (int k = 0; k < 3; k++) begin
            if (r < bounds[lvl][k]) return 3'(k);
        end
        return 3'd3;
    endfunction

    int           cyc = 0;
    int           m_pick_at = -1;
    int           m_issue_at = -1;
    int           m_free = 0;
    int           m_ptr = N - 1;
    int           m_sel = 0;
    int           m_cnt = 0;
    int           m_lvl = 0;
    int           mc;
    logic [15:0]  m_lfsr = SEED;
    logic [2:0]   m_prev = 3'd0;
    logic [2:0]   m_pick_type = 3'd0;
    logic [N-1:0] exp_grant = '0;
    logic         exp_valid = 1'b0;
    logic [2:0]   exp_type = 3'd0;
    logic [1:0]   exp_level = 2'd0;

    // Work is scheduled by cycle number: a tick at c picks at c+1 and issues at c+2.
    always @(posedge Clk) begin
        mc = cyc;
        if (Reset) begin
            m_lfsr = SEED; m_ptr = N - 1; m_prev = 3'd0; m_cnt = 0; m_lvl = 0;
            m_pick_at = -1; m_issue_at = -1; m_free = 0;
        end else begin
            if (mc == m_issue_at) begin
                m_ptr  = m_sel;
                m_prev = m_pick_type;
                m_cnt++;
                if (m_cnt == STEP) begin
                    m_cnt = 0;
                    if (m_lvl < 3) m_lvl++;
                end
            end
            if (mc == m_pick_at && respawn_req != '0) begin
                m_sel = -1;
                for (int i = 1; i <= N; i++) begin
                    if (m_sel < 0 && respawn_req[(m_ptr + i) % N]) m_sel = (m_ptr + i) % N;
                end
                m_pick_type = ref_type(m_lvl, int'(m_lfsr[3:0]));
                if (m_pick_type == 3'd1 && m_prev == 3'd1) m_pick_type = 3'd0;
                m_issue_at = mc + 1;
                m_free     = mc + 2;
            end
            if (mc >= m_free && frame_tick && respawn_req != '0) begin
                m_pick_at = mc + 1;
                m_free    = mc + 2;
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
        cyc++;
        exp_valid = (m_issue_at == cyc);
        exp_grant = '0;
        if (exp_valid) exp_grant[m_sel] = 1'b1;
        exp_type  = exp_valid ? m_pick_type : m_prev;
        exp_level = 2'(m_lvl);
    end

    task automatic pulse_reset();
        Reset = 1'b1;
        frame_tick = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            tests++;
            if (grant !== '0 || type_valid !== 1'b0) begin
                fails++; $display("FAIL reset_outputs grant=%b valid=%b want 0/0", grant, type_valid);
            end
            tests++;
            if (type_trigger !== 3'b000 || level !== 2'd0) begin
                fails++; $display("FAIL reset_type_level type=%b level=%0d want 000/0", type_trigger, level);
            end
        end
        Reset = 1'b0;
        @(negedge Clk);
        tests++;
        if (state_dbg !== 2'd0 || grant !== '0) begin
            fails++; $display("FAIL reset_idle state=%0d grant=%b want 0/0", state_dbg, grant);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        respawn_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            frame_tick = 1'b1;
            want = '0;
            want[k] = 1'b1;
            for (int i = 1; i <= 10; i++) begin
                @(negedge Clk);
                frame_tick = 1'b0;
                tests++;
                if (grant !== exp_grant) begin
                    fails++; $display("FAIL rr_model_grant got=%b want=%b", grant, exp_grant);
                end
                tests++;
                if (i == 2 && (grant !== want || type_valid !== 1'b1)) begin
                    fails++; $display("FAIL rr_grant k=%0d got=%b/%b want=%b/1", k, grant, type_valid, want);
                end else if (i != 2 && grant !== '0) begin
                    fails++; $display("FAIL rr_idle k=%0d i=%0d got=%b want 0", k, i, grant);
                end
                tests++;
                if (type_trigger !== 3'b000 || level !== 2'd0) begin
                    fails++; $display("FAIL rr_type_level type=%b level=%0d want 000/0", type_trigger, level);
                end
            end
        end
    endtask

    task automatic test_level_ramp();
        int ngr = 0;
        int want_lvl;
        pulse_reset();
        respawn_req = 4'b0001;
        frame_tick = 1'b1;
        for (int i = 0; i < 400 && ngr < 100; i++) begin
            @(negedge Clk);
            want_lvl = (ngr / STEP > 3) ? 3 : ngr / STEP;
            tests++;
            if (level !== 2'(want_lvl)) begin
                fails++; $display("FAIL level_ramp grants=%0d got=%0d want=%0d", ngr, level, want_lvl);
            end
            tests++;
            if (grant !== exp_grant || type_trigger !== exp_type) begin
                fails++; $display("FAIL level_model grant=%b type=%b want %b/%b", grant, type_trigger, exp_grant, exp_type);
            end
            if (type_valid) ngr++;
        end
        frame_tick = 1'b0;
        tests++;
        if (ngr < 100) begin
            fails++; $display("FAIL level_timeout grants=%0d want 100", ngr);
        end
    endtask

    task automatic test_req_drop();
        repeat (3) @(negedge Clk);
        respawn_req = 4'b0100;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        respawn_req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            tests++;
            if (grant !== '0 || type_valid !== 1'b0 || grant !== exp_grant) begin
                fails++; $display("FAIL drop_no_grant i=%0d grant=%b valid=%b want 0/0", i, grant, type_valid);
            end
            if (i == 0) begin
                tests++;
                if (state_dbg !== 2'd0) begin
                    fails++; $display("FAIL drop_idle state=%0d want 0", state_dbg);
                end
            end
        end
        respawn_req = 4'b0100;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        tests++;
        if (grant !== 4'b0100 || type_trigger !== exp_type || level !== exp_level) begin
            fails++; $display("FAIL drop_regrant grant=%b type=%b lvl=%0d want 0100/%b/%0d", grant, type_trigger, level, exp_type, exp_level);
        end
    endtask

    task automatic test_back_to_back();
        int last_cyc = -1;
        logic [N-1:0] last_g = '0;
        respawn_req = 4'b0011;
        frame_tick = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            tests++;
            if (grant !== exp_grant || $countones(grant) > 1) begin
                fails++; $display("FAIL b2b_grant got=%b want=%b", grant, exp_grant);
            end
            if (grant != '0) begin
                tests++;
                if (!(grant == 4'b0001 || grant == 4'b0010) || grant == last_g ||
                    (last_cyc >= 0 && i - last_cyc != 3)) begin
                    fails++; $display("FAIL b2b_alternate got=%b prev=%b gap=%0d want other slot gap 3", grant, last_g, i - last_cyc);
                end
                last_g = grant;
                last_cyc = i;
            end
        end
        frame_tick = 1'b0;
    endtask

    task automatic test_level3_types();
        int ngr = 0;
        int n3 = 0;
        logic [2:0] last_t = 3'd0;
        logic [3:0] seen = '0;
        pulse_reset();
        for (int i = 0; i < 8000 && n3 < 500; i++) begin
            respawn_req = 4'($urandom_range(0, 15));
            frame_tick = ($urandom_range(0, 3) != 0);
            @(negedge Clk);
            tests++;
            if (grant !== exp_grant || type_valid !== exp_valid || type_trigger !== exp_type || level !== exp_level) begin
                fails++; $display("FAIL l3_model g=%b v=%b t=%b l=%0d want %b/%b/%b/%0d",
                                  grant, type_valid, type_trigger, level, exp_grant, exp_valid, exp_type, exp_level);
            end
            tests++;
            if (type_trigger > 3'b011) begin
                fails++; $display("FAIL l3_range got=%b want <=011", type_trigger);
            end
            tests++;
            if (type_valid && type_trigger == 3'd1 && last_t == 3'd1) begin
                fails++; $display("FAIL l3_brown_pair got=%b prev=%b want not both 001", type_trigger, last_t);
            end else if (!type_valid && type_trigger !== last_t) begin
                fails++; $display("FAIL l3_hold got=%b want %b", type_trigger, last_t);
            end
            if (type_valid) begin
                last_t = type_trigger;
                if (ngr >= 3 * STEP) begin
                    seen[type_trigger[1:0]] = 1'b1;
                    n3++;
                end
                ngr++;
            end
        end
        frame_tick = 1'b0;
        tests++;
        if (n3 < 500 || seen !== 4'b1111) begin
            fails++; $display("FAIL l3_coverage grants=%0d seen=%b want 500/1111", n3, seen);
        end
    endtask

    task automatic test_reset_in_issue();
        int ngr = 0;
        int i = 0;
        pulse_reset();
        respawn_req = 4'b0001;
        frame_tick = 1'b1;
        while (i < 400 && !(ngr >= 2 * STEP && m_pick_at == cyc)) begin
            @(negedge Clk);
            if (type_valid) ngr++;
            i++;
        end
        tests++;
        if (level !== 2'd2 || m_pick_at != cyc) begin
            fails++; $display("FAIL rst_issue_setup level=%0d grants=%0d want 2/32", level, ngr);
        end
        Reset = 1'b1;
        frame_tick = 1'b0;
        @(negedge Clk);
        tests++;
        if (grant !== '0 || type_valid !== 1'b0 || type_trigger !== 3'b000 || level !== 2'd0) begin
            fails++; $display("FAIL rst_issue_during g=%b v=%b t=%b l=%0d want 0/0/000/0", grant, type_valid, type_trigger, level);
        end
        Reset = 1'b0;
        @(negedge Clk);
        tests++;
        if (grant !== '0 || type_trigger !== 3'b000 || level !== 2'd0) begin
            fails++; $display("FAIL rst_issue_after g=%b t=%b l=%0d want 0/000/0", grant, type_trigger, level);
        end
        respawn_req = 4'b1111;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        tests++;
        if (grant !== 4'b0001 || type_valid !== 1'b1) begin
            fails++; $display("FAIL rst_issue_regrant g=%b v=%b want 0001/1", grant, type_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_level_ramp();
        test_req_drop();
        test_back_to_back();
        test_level3_types();
        test_reset_in_issue();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
